ili_pio_strobe: RTL
===================

Name: ili_pio_strobe

Overview:
- Parametrised Avalon-MM output PIO for the ILI9341 TFT control bus (nWR, nRD, RS, nCS, data lines), replacing single-bit PIOs.
- Adds atomic set/clear registers and a hardware strobe generator that toggles masked bits for a fixed number of cycles, then enforces a recovery gap.
- Removes the write-1/write-0 software sequence per TFT write cycle.
- Sits between the Nios II data master and the TFT pins.

Parameters:
- WIDTH, 8, output port width, 1..32
- RESET_VALUE, 8'hFF, out_port value after reset (control lines idle high)
- PULSE_CYCLES, 2, strobe active width in clk cycles, 1..255
- GAP_CYCLES, 1, recovery cycles after strobe before next strobe accepted, 0..255

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select: 0 DATA, 1 STROBE, 2 SET, 3 CLEAR
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- readdata  out  32  combinational read data
- waitrequest  out  1  stalls STROBE writes while strobe engine busy
- out_port  out  WIDTH  pin drive
- busy  out  1  strobe engine not IDLE

Behaviour:
- Write condition: wr = chipselect & ~write_n.
- Reset (sampled at clk rising edge):
  - data_reg = RESET_VALUE, pulse_mask = 0, state = IDLE, counter = 0.
  - out_port = RESET_VALUE, busy = 0.
  - Reset mid-strobe aborts the strobe immediately; there is no partial recovery gap.
- DATA (addr 0):
  - Write: data_reg <= writedata[WIDTH-1:0].
  - Read: zero-extended data_reg (not out_port).
- SET (addr 2): write does data_reg <= data_reg | writedata[WIDTH-1:0]; reads 0.
- CLEAR (addr 3): write does data_reg <= data_reg & ~writedata[WIDTH-1:0]; reads 0.
- STROBE (addr 1):
  - Read: {31'b0, busy}.
  - Write in IDLE with mask m = writedata[WIDTH-1:0] != 0: pulse_mask <= m, counter <= PULSE_CYCLES-1, state <= ACTIVE.
  - Write with m == 0: no-op, engine stays IDLE.
- out_port = data_reg ^ (state==ACTIVE ? pulse_mask : 0), driven from registered state. No glitch path through the bus inputs.
- Latency: a STROBE write accepted at edge k gives out_port toggled from cycle k+1 for exactly PULSE_CYCLES cycles.
- FSM states IDLE, ACTIVE, RECOVER:
  - IDLE -> ACTIVE on accepted nonzero STROBE write.
  - ACTIVE: counter decrements each cycle. At counter==0: go to RECOVER with counter <= GAP_CYCLES-1 if GAP_CYCLES>0, else go to IDLE and clear pulse_mask.
  - RECOVER: counter decrements; at counter==0 go to IDLE and clear pulse_mask.
- busy = (state != IDLE).
- waitrequest = wr & (address==1) & busy, combinational.
  - A stalled STROBE write is held by the master and accepted in the first IDLE cycle.
  - Back-to-back strobes are therefore spaced PULSE_CYCLES+GAP_CYCLES+1 cycles apart, edge to edge.
  - waitrequest is never asserted for addresses 0, 2, 3.
- DATA/SET/CLEAR writes during ACTIVE update data_reg at once. out_port reflects the new data_reg XOR pulse_mask on the next cycle. The strobe timing is unaffected.
- Counter width is 8 bits; no wrap-around is possible within the parameter limits.
- Writes of bits above WIDTH are ignored.
- Reads of all unused readdata bits return 0.

Decomposition:
- Package ili_pio_pkg:
  - register offset constants ADDR_DATA=0, ADDR_STROBE=1, ADDR_SET=2, ADDR_CLEAR=3
  - state enum {IDLE, ACTIVE, RECOVER}
  - COUNT_W=8
- One sub-module, ili_pulse_timer:
  - contains the FSM and counter
  - inputs: start, PULSE_CYCLES, GAP_CYCLES
  - outputs: active, busy
- Top level holds data_reg, pulse_mask, address decode and the read mux.

Test Plan:
1. Reset: assert reset 2 cycles -> out_port=8'hFF, busy=0, readdata at addr 0 = 32'h000000FF.
2. Write DATA 8'hA5, then SET 8'h0A, then CLEAR 8'h81 -> out_port 8'hA5, then 8'hAF, then 8'h2E. SET/CLEAR reads return 0.
3. PULSE_CYCLES=2, GAP_CYCLES=1, data 8'hFF, STROBE 8'h01 at edge k -> out_port=8'hFE in cycles k+1..k+2, 8'hFF from k+3; busy high k+1..k+3.
4. STROBE write held during busy -> waitrequest=1 until IDLE, accepted at edge k+4. Second pulse is low k+5..k+6; no overlap with the first.
5. STROBE write with mask 0 -> busy stays 0, no waitrequest, out_port unchanged.
6. Reset at ACTIVE cycle k+1 -> next cycle out_port=RESET_VALUE, busy=0. A CLEAR 8'h10 written during ACTIVE shows on out_port with the pulse bit still inverted.

Source files
------------

// File: rtl/ili_pio_strobe_pkg.sv
// Shared constants and types for the ILI9341 strobe PIO: register map,
// strobe engine states and counter width.
package ili_pio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STROBE = 2'd1;
    localparam logic [1:0] ADDR_SET    = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RECOVER = 2'd2
    } state_e;

endpackage

// File: rtl/ili_pio_strobe_if.sv
// Avalon-MM slave bus between the Nios II data master and the strobe PIO.
// Handshake: a write is taken on a rising clk edge when chipselect=1, write_n=0
// and waitrequest=0; while waitrequest=1 the master holds address/writedata
// stable. readdata is combinational from address.
interface ili_pio_strobe_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/ili_pio_strobe_pulse_timer.sv
// Strobe engine: holds the pulse for PULSE_CYCLES clocks, then a GAP_CYCLES
// recovery window during which no new strobe is accepted.
module ili_pulse_timer
    import ili_pio_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       active,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ACTIVE  = ACTIVE;
    localparam logic [1:0] S_RECOVER = RECOVER;

    localparam logic [COUNT_W-1:0] PULSE_LOAD = COUNT_W'(PULSE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] GAP_LOAD   =
        (GAP_CYCLES > 0) ? COUNT_W'(GAP_CYCLES - 1) : '0;

    logic [COUNT_W-1:0] counter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ACTIVE;
                        counter <= PULSE_LOAD;
                    end
                end
                S_ACTIVE: begin
                    if (counter == '0) begin
                        // A zero gap returns straight to IDLE with no recovery cycle.
                        if (GAP_CYCLES > 0) begin
                            state   <= S_RECOVER;
                            counter <= GAP_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (counter == '0) begin
                        state <= S_IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    assign active = (state == S_ACTIVE);
    assign busy   = (state != S_IDLE);

endmodule

// File: rtl/ili_pio_strobe.sv
// Output PIO for the ILI9341 control/data pins with atomic set/clear and a
// hardware strobe that inverts masked bits for a fixed pulse width.
module ili_pio_strobe
    import ili_pio_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'hFF,
    parameter int          PULSE_CYCLES = 2,
    parameter int          GAP_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    ili_pio_strobe_if.slave   bus,
    output logic [WIDTH-1:0]  out_port,
    output logic              busy
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] pulse_mask;
    logic [WIDTH-1:0] wr_bits;
    logic             wr;
    logic             start;
    logic             active;
    logic [1:0]       timer_state;
    logic             unused_wr_high;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_bits = bus.writedata[WIDTH-1:0];
    assign unused_wr_high = ^bus.writedata;

    // An all-zero mask would strobe nothing, so it never leaves IDLE.
    assign start = wr & (bus.address == ADDR_STROBE) & ~busy & (wr_bits != '0);

    assign bus.waitrequest = wr & (bus.address == ADDR_STROBE) & busy;

    ili_pulse_timer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .active (active),
        .busy   (busy),
        .state  (timer_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= RESET_VALUE[WIDTH-1:0];
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:  data_reg <= wr_bits;
                ADDR_SET:   data_reg <= data_reg | wr_bits;
                ADDR_CLEAR: data_reg <= data_reg & ~wr_bits;
                default:    data_reg <= data_reg;
            endcase
        end
    end

    // The mask only matters while ACTIVE; it is dropped once the engine is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_mask <= '0;
        end else if (start) begin
            pulse_mask <= wr_bits;
        end else if (!busy) begin
            pulse_mask <= '0;
        end
    end

    assign out_port = data_reg ^ (active ? pulse_mask : '0);

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata[WIDTH-1:0] = data_reg;
            ADDR_STROBE: bus.readdata[0]         = busy;
            default:     bus.readdata            = '0;
        endcase
    end

    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        timer_state != 2'b11);

endmodule
